// File: rtl/traffic_phase_scheduler.sv
// Round-robin green/yellow/all-red phase sequencer for four approaches (NS1, NS2, EW1, EW2).
// Optional emergency preemption is enabled by defining EMERG_PREEMPT_EN.
`timescale 1ns/1ps
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int EXT_STEP  = 5,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       demand,
    input  logic [3:0]       congest,
`ifdef EMERG_PREEMPT_EN
    input  logic [3:0]       emerg_req,
`endif
    output logic [3:0]       grant,
    output logic [3:0]       yellow,
    output logic             all_red,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] green_cnt
);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'b00,
        S_GREEN   = 2'b01,
        S_YELLOW  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] T_GMIN   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_EXT    = CNT_W'(EXT_STEP - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_T - 1);

    state_t           state_r;
    logic [CNT_W-1:0] timer_r;
    logic [1:0]       last_r;
    logic [1:0]       cur_r;

    logic [1:0]       rr_cand_s;
    logic [1:0]       sel_idx_s;
    logic             sel_vld_s;
    logic             other_s;
    logic             hold_s;
    logic             preempt_s;
    logic             ext_ok_s;
    logic [CNT_W-1:0] cnt_inc_s;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Next-approach selection, green hold/extension decisions and the saturating count.
    always_comb begin
        rr_cand_s = 2'd0;
        sel_idx_s = 2'd0;
        sel_vld_s = 1'b0;
        // Scan backwards so the nearest approach after last_r is the one kept.
        for (int i = 4; i >= 1; i--) begin
            rr_cand_s = last_r + 2'(i);
            if (demand[rr_cand_s]) begin
                sel_idx_s = rr_cand_s;
                sel_vld_s = 1'b1;
            end else begin
                sel_vld_s = sel_vld_s;
            end
        end
        other_s = |(demand & ~onehot(cur_r));
`ifdef EMERG_PREEMPT_EN
        for (int i = 3; i >= 0; i--) begin
            if (emerg_req[i]) begin
                sel_idx_s = 2'(i);
                sel_vld_s = 1'b1;
            end else begin
                sel_vld_s = sel_vld_s;
            end
        end
        preempt_s = |(emerg_req & ~onehot(cur_r));
        hold_s    = ~other_s | emerg_req[cur_r];
`else
        preempt_s = 1'b0;
        hold_s    = ~other_s;
`endif
        // Extension is judged on the count after this cycle, keeping the total strictly inside GREEN_MAX.
        ext_ok_s  = (int'(green_cnt) + 32'sd2 + EXT_STEP) <= GREEN_MAX;
        if (green_cnt == CNT_MAX) begin
            cnt_inc_s = green_cnt;
        end else begin
            cnt_inc_s = green_cnt + ONE;
        end
    end

    // Phase state machine with registered light outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_ALL_RED;
            timer_r   <= T_ALLRED;
            last_r    <= 2'd3;
            cur_r     <= 2'd0;
            grant     <= 4'b0000;
            yellow    <= 4'b0000;
            all_red   <= 1'b1;
            phase     <= 2'b00;
            green_cnt <= ZERO;
        end else begin
            case (state_r)
                S_ALL_RED: begin
                    if (timer_r != ZERO) begin
                        timer_r <= timer_r - ONE;
                    end else if (sel_vld_s) begin
                        state_r   <= S_GREEN;
                        cur_r     <= sel_idx_s;
                        last_r    <= sel_idx_s;
                        timer_r   <= T_GMIN;
                        grant     <= onehot(sel_idx_s);
                        all_red   <= 1'b0;
                        phase     <= 2'b01;
                        green_cnt <= ZERO;
                    end else begin
                        timer_r <= ZERO;
                    end
                end
                S_GREEN: begin
                    green_cnt <= cnt_inc_s;
                    if (preempt_s) begin
                        state_r   <= S_YELLOW;
                        timer_r   <= T_YELLOW;
                        grant     <= 4'b0000;
                        yellow    <= onehot(cur_r);
                        phase     <= 2'b10;
                        green_cnt <= ZERO;
                    end else if (timer_r != ZERO) begin
                        timer_r <= timer_r - ONE;
                    end else if (hold_s) begin
                        timer_r <= ZERO;
                    end else if (congest[cur_r] && ext_ok_s) begin
                        timer_r <= T_EXT;
                    end else begin
                        state_r   <= S_YELLOW;
                        timer_r   <= T_YELLOW;
                        grant     <= 4'b0000;
                        yellow    <= onehot(cur_r);
                        phase     <= 2'b10;
                        green_cnt <= ZERO;
                    end
                end
                S_YELLOW: begin
                    if (timer_r != ZERO) begin
                        timer_r <= timer_r - ONE;
                    end else begin
                        state_r <= S_ALL_RED;
                        timer_r <= T_ALLRED;
                        yellow  <= 4'b0000;
                        all_red <= 1'b1;
                        phase   <= 2'b00;
                    end
                end
                default: begin
                    state_r   <= S_ALL_RED;
                    timer_r   <= T_ALLRED;
                    grant     <= 4'b0000;
                    yellow    <= 4'b0000;
                    all_red   <= 1'b1;
                    phase     <= 2'b00;
                    green_cnt <= ZERO;
                end
            endcase
        end
    end

endmodule
